// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-period math, frame lengths.
// No logic; constants and a constant function only.
// Meant to be shared by the receiver and a future transmitter.
package uart_pkg;

  localparam int unsigned UART_START_BITS = 1;
  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_STOP_BITS  = 1;

  // Receiver states. PARITY is only reachable when the parity build option is on.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_state_t;

  // clk cycles per bit. The division is truncated, so the baud error is absorbed
  // by mid-bit sampling.
  function automatic int unsigned uart_bit_cnt(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detect.
// Latency: rx_s lags the pin by 2 clk; fall_s is combinational on rx_s.
// No backpressure. fall_s is suppressed until a real high has been seen after reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_async,
  output logic rx_s,
  output logic fall_s
);

  logic       meta_q, meta_d;
  logic       sync_q, sync_d;
  logic       prev_q, prev_d;
  logic [1:0] fill_q, fill_d;

  // Shift the line through the synchronizer. Track when sync_q holds a real
  // sample, so the reset value of 1 cannot fake a falling edge on a low line.
  always_comb begin
    meta_d = rx_async;
    sync_d = meta_q;
    fill_d = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    prev_d = (fill_q == 2'd2) ? sync_q : 1'b0;
  end

  // State registers; the synchronizer flops reset to the idle-high level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b0;
      fill_q <= 2'd0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      fill_q <= fill_d;
    end
  end

  assign rx_s   = sync_q;
  assign fall_s = prev_q & ~sync_q;

endmodule

// File: rtl/uart_byte_rx.sv
// UART byte receiver: 8 data bits LSB first, 3-sample majority per bit, optional even parity (UART_RX_PARITY_EN).
// Latency: o_rx_valid rises one clk after the last stop-bit sample (2 clk sync + 9.5 bit times + 2 clk after the start edge).
// No backpressure: strobes are single-cycle and must be taken when they occur.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 148500000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_frame_err,
  output logic       o_parity_err
);

  localparam int unsigned BIT_CNT = uart_bit_cnt(CLK_FREQ, BAUD);
  localparam int unsigned CNT_W   = $clog2(BIT_CNT) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] SMP_0    = CNT_W'(BIT_CNT / 2 - 1);
  localparam logic [CNT_W-1:0] SMP_1    = CNT_W'(BIT_CNT / 2);
  localparam logic [CNT_W-1:0] SMP_2    = CNT_W'(BIT_CNT / 2 + 1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic rx_s;
  logic fall_s;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .rx_async (i_uart_rx),
    .rx_s     (rx_s),
    .fall_s   (fall_s)
  );

  uart_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [1:0]       smp_q, smp_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             maj;

`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
  logic             perr_q, perr_d;
`endif

  // Majority of the two stored samples and the live third sample; only
  // meaningful in the cycle where cnt_q == SMP_2.
  assign maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

  // Next-state, bit timing, sampling and strobe generation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    smp_d     = smp_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    perr_d    = 1'b0;
`endif

    if (cnt_q == SMP_0) smp_d[0] = rx_s;
    if (cnt_q == SMP_1) smp_d[1] = rx_s;

    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (fall_s) state_d = ST_START;
      end

      ST_START: begin
        if (cnt_q == SMP_2 && maj) begin
          // Line went back high before mid-bit: treat it as noise.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end

      ST_DATA: begin
        if (cnt_q == SMP_2) shift_d = {maj, shift_q[7:1]};
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == SMP_2) par_d = maj;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_STOP;
          cnt_d   = '0;
        end
      end
`endif

      ST_STOP: begin
        // Decide at the last stop sample and leave early, so a start bit that
        // immediately follows the stop bit is still caught.
        if (cnt_q == SMP_2) begin
          cnt_d = '0;
          if (maj) begin
            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            if (^{shift_q, par_q}) begin
              perr_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end
`else
            valid_d = 1'b1;
            data_d  = shift_q;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_IDLE;
          end
        end
      end

      ST_WAIT_IDLE: begin
        // Hold off through a break so it reports only one framing error.
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      smp_q     <= '0;
      shift_q   <= '0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      smp_q     <= smp_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity bit and parity-error strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_rx_data   = data_q;
  assign o_rx_valid  = valid_q;
  assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at 10 clk per bit.
// The driver advances one negedge at a time and records every strobe it sees.
// Expected values are hand-derived constants.
module tb_uart_byte_rx;
  import uart_pkg::*;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_frame_err;
  logic       o_parity_err;

  uart_byte_rx #(
    .CLK_FREQ (1000000),
    .BAUD     (100000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_uart_rx    (rx),
    .o_rx_data    (o_rx_data),
    .o_rx_valid   (o_rx_valid),
    .o_frame_err  (o_frame_err),
    .o_parity_err (o_parity_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A line edge driven at a negedge is captured on the next posedge; the valid
  // flop loads 99 posedges after that, and is seen on the following negedge.
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 110;
`else
  localparam int LAT = 100;
`endif

  int         n_chk  = 0;
  int         n_pass = 0;
  int         cyc    = 0;
  int         ferr_n = 0;
  int         perr_n = 0;
  int         both_n = 0;
  int         t0;
  logic [7:0] vq[$];
  int         vt[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (o_rx_valid === 1'b1) begin
      vq.push_back(o_rx_data);
      vt.push_back(cyc);
    end
    if (o_frame_err === 1'b1) ferr_n++;
    if (o_parity_err === 1'b1) perr_n++;
    if (o_rx_valid === 1'b1 && o_frame_err === 1'b1) both_n++;
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) tick();
  endtask

  task automatic clear_mon();
    vq.delete();
    vt.delete();
    ferr_n = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par);
    repeat (UART_START_BITS) drive_bit(1'b0, 10);
    for (int i = 0; i < UART_DATA_BITS; i++) drive_bit(b[i], 10);
`ifdef UART_RX_PARITY_EN
    drive_bit(par, 10);
`else
    if (par !== 1'bx) rx = 1'b1;
`endif
    repeat (UART_STOP_BITS) drive_bit(1'b1, 10);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, ^b);
  endtask

  logic [7:0] b81;

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) tick();
    chk("reset_data",   32'(o_rx_data),    32'h00);
    chk("reset_valid",  32'(o_rx_valid),   32'h0);
    chk("reset_ferr",   32'(o_frame_err),  32'h0);
    chk("reset_perr",   32'(o_parity_err), 32'h0);
    chk("reset_state",  32'(dut.state_q),  32'(ST_IDLE));
    rst = 1'b0;
    drive_bit(1'b1, 10);

    // Single byte with latency check.
    clear_mon();
    t0 = cyc;
    send_byte(8'hA5);
    drive_bit(1'b1, 10);
    chk("a5_count", 32'(vq.size()), 32'd1);
    if (vq.size() > 0) begin
      chk("a5_data",    32'(vq[0]),      32'hA5);
      chk("a5_latency", 32'(vt[0] - t0), 32'(LAT));
    end
    chk("a5_out_data", 32'(o_rx_data), 32'hA5);
    chk("a5_ferr",     32'(ferr_n),    32'd0);

    // Back-to-back frames, no idle between stop and next start.
    clear_mon();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h55);
    drive_bit(1'b1, 10);
    chk("b2b_count", 32'(vq.size()), 32'd3);
    if (vq.size() == 3) begin
      chk("b2b_0", 32'(vq[0]), 32'h00);
      chk("b2b_1", 32'(vq[1]), 32'hFF);
      chk("b2b_2", 32'(vq[2]), 32'h55);
    end
    chk("b2b_ferr", 32'(ferr_n), 32'd0);

    // Short low glitch on an idle line.
    clear_mon();
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 20);
    chk("glitch_valid", 32'(vq.size()),   32'd0);
    chk("glitch_ferr",  32'(ferr_n),      32'd0);
    chk("glitch_state", 32'(dut.state_q), 32'(ST_IDLE));

    // Break: 30 bit times low.
    clear_mon();
    drive_bit(1'b0, 300);
    drive_bit(1'b1, 20);
    chk("break_ferr",  32'(ferr_n),      32'd1);
    chk("break_valid", 32'(vq.size()),   32'd0);
    chk("break_data",  32'(o_rx_data),   32'h55);
    chk("break_state", 32'(dut.state_q), 32'(ST_IDLE));
    clear_mon();
    send_byte(8'h3C);
    drive_bit(1'b1, 10);
    chk("post_break_count", 32'(vq.size()), 32'd1);
    if (vq.size() > 0) chk("post_break_data", 32'(vq[0]), 32'h3C);

    // Reset in the middle of bit 4 of 0x81.
    clear_mon();
    b81 = 8'h81;
    drive_bit(1'b0, 10);
    for (int i = 0; i < 4; i++) drive_bit(b81[i], 10);
    drive_bit(b81[4], 5);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("midrst_data", 32'(o_rx_data), 32'h00);
    drive_bit(b81[4], 5);
    for (int i = 5; i < 8; i++) drive_bit(b81[i], 10);
`ifdef UART_RX_PARITY_EN
    drive_bit(^b81, 10);
`endif
    drive_bit(1'b1, 30);
    chk("midrst_valid", 32'(vq.size()), 32'd0);
    chk("midrst_ferr",  32'(ferr_n),    32'd0);
    send_byte(8'h7E);
    drive_bit(1'b1, 10);
    chk("after_rst_count", 32'(vq.size()), 32'd1);
    if (vq.size() > 0) chk("after_rst_data", 32'(vq[0]), 32'h7E);
    chk("after_rst_out", 32'(o_rx_data), 32'h7E);

`ifdef UART_RX_PARITY_EN
    // 0x01 needs parity 1 for even parity over data plus parity.
    clear_mon();
    perr_n = 0;
    send_frame(8'h01, 1'b0);
    drive_bit(1'b1, 10);
    chk("par_bad_perr",  32'(perr_n),    32'd1);
    chk("par_bad_valid", 32'(vq.size()), 32'd0);
    chk("par_bad_data",  32'(o_rx_data), 32'h7E);
    clear_mon();
    perr_n = 0;
    send_frame(8'h01, 1'b1);
    drive_bit(1'b1, 10);
    chk("par_ok_perr",  32'(perr_n),    32'd0);
    chk("par_ok_count", 32'(vq.size()), 32'd1);
    if (vq.size() > 0) chk("par_ok_data", 32'(vq[0]), 32'h01);
`else
    chk("perr_never", 32'(perr_n), 32'd0);
`endif
    chk("valid_ferr_overlap", 32'(both_n), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
